dmem_responder: RTL

- Responder end of the CPU data-memory interface. Serves the load/store address, write data and write enable driven by the core. Returns read data in the same cycle.
- Backs a word RAM plus a small memory-mapped I/O window:
  - console TX FIFO with a valid/ready drain port
  - free-running cycle timer with a compare interrupt
- Sits beside the core in the SoC top, wired to the core's MemWrite, Mem_WrAddr, Mem_WrData and ReadData.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM, console TX FIFO, cycle timer
// Optional bus error reporting is enabled with the DMEM_ERR_EN macro.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
`ifdef DMEM_ERR_EN
    input  logic        mem_re,
    output logic        bus_err,
`endif
    output logic        timer_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      ram_q [0:2**ADDR_W-1];
    logic [7:0]       fifo_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [31:0]      mtime_q, mtimecmp_q, mtime_d;
    logic             irq_q;

    logic             is_ram, is_mmio;
    logic [1:0]       reg_sel;
    logic             fifo_empty, fifo_full, push_req, pop, push_ok;
    logic             ovf_set, ovf_clr;

    assign is_ram  = (mem_addr[31:ADDR_W+2] == '0);
    assign is_mmio = (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel = mem_addr[3:2];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && con_ready;
    assign push_req   = mem_we && is_mmio && (reg_sel == 2'd0);
    // A full FIFO can still accept a byte when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = mem_we && is_mmio && (reg_sel == 2'd1) && mem_wdata[2];

    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign timer_irq = irq_q;

    always_comb begin
        mem_rdata = 32'h0;
        if (is_ram) begin
            mem_rdata = ram_q[mem_addr[ADDR_W+1:2]];
        end else if (is_mmio) begin
            case (reg_sel)
                2'd1:    mem_rdata = {29'b0, overflow_q, fifo_full, fifo_empty};
                2'd2:    mem_rdata = mtime_q;
                2'd3:    mem_rdata = mtimecmp_q;
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        mtime_d = mtime_q + 32'd1;
        if (mem_we && is_mmio && (reg_sel == 2'd2)) begin
            mtime_d = mem_wdata;
        end
    end

    // Storage arrays carry no reset; a store during reset is still suppressed.
    always_ff @(posedge clk) begin
        if (!reset && mem_we && is_ram) begin
            ram_q[mem_addr[ADDR_W+1:2]] <= mem_wdata;
        end
        if (!reset && push_ok) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mtime_q    <= 32'h0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            irq_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            mtime_q <= mtime_d;
            if (mem_we && is_mmio && (reg_sel == 2'd3)) begin
                mtimecmp_q <= mem_wdata;
            end
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

`ifdef DMEM_ERR_EN
    logic bus_err_q;
    logic access;

    assign access  = mem_we || mem_re;
    assign bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if ((access && !is_ram && !is_mmio) || (mem_we && (mem_addr[1:0] != 2'b00))) begin
            bus_err_q <= 1'b1;
        end
    end
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, mem_addr[1:0]};
`endif
endmodule
